// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings and refresh FSM states.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_RP,
    AREF,
    WAIT_RFC
  } ref_state_t;

  // Command driven on the bus while the refresh engine sits in a given state.
  function automatic logic [3:0] ref_cmd(input ref_state_t st);
    case (st)
      PRE:     return CMD_PRE;
      AREF:    return CMD_AREF;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer: counts 0..REF_PERIOD-1 while enabled
// and flags the terminal count.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PERIOD = 750
) (
  input  logic sclk,
  input  logic s_rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(REF_PERIOD - 1));
  assign tick   = enable & at_end;

  // Next count: advance while enabled, wrap on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_ref_ctrl.sv
// SDRAM auto-refresh engine: accumulates refresh debt from the interval timer
// and, once granted, issues PRECHARGE-ALL then one AUTO-REFRESH per debt unit.
// T_RP and T_RFC must be at least 2.
module sdram_ref_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PERIOD = 750,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 4,
  parameter int unsigned MAX_DEBT   = 8,
  parameter int unsigned URGENT_TH  = 6,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned BANK_W     = 2,
  parameter int unsigned A10_BIT    = 10
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              flag_init_end,
  input  logic              ref_en,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic              ref_busy,
  output logic              flag_ref_end,
  output logic              ref_overflow,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank
);

  localparam int unsigned DEBT_W = $clog2(MAX_DEBT + 1);
  localparam int unsigned T_MAX  = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned WAIT_W = $clog2(T_MAX) + 1;

  localparam logic [WAIT_W-1:0] RP_LAST  = WAIT_W'(T_RP - 2);
  localparam logic [WAIT_W-1:0] RFC_LAST = WAIT_W'(T_RFC - 2);
  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG = DEBT_W'(URGENT_TH);

  ref_state_t        state_q, state_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic [DEBT_W-1:0] n_q, n_d;
  logic [DEBT_W-1:0] left_q, left_d;
  logic [DEBT_W-1:0] debt_base;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              init_seen_q, init_seen_d;
  logic              done;
  logic              tick;

  logic              req_q, req_d;
  logic              urgent_q, urgent_d;
  logic              busy_q, busy_d;
  logic              end_q, end_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_timer (
    .sclk   (sclk),
    .s_rst  (s_rst),
    .enable (init_seen_q),
    .tick   (tick)
  );

  // Burst sequencing: PRE, tRP gap, then n AREFs each followed by a tRFC gap.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    left_d  = left_q;
    wait_d  = wait_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_en && req_q) begin
          state_d = PRE;
          n_d     = debt_q;
          left_d  = debt_q;
        end
      end
      PRE: begin
        state_d = WAIT_RP;
        wait_d  = '0;
      end
      WAIT_RP: begin
        if (wait_q == RP_LAST) begin
          state_d = AREF;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      AREF: begin
        state_d = WAIT_RFC;
        wait_d  = '0;
        left_d  = left_q - 1'b1;
      end
      WAIT_RFC: begin
        if (wait_q == RFC_LAST) begin
          if (left_q != '0) begin
            state_d = AREF;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Debt bookkeeping: completion retires the frozen n, a tick adds one.
  always_comb begin
    init_seen_d = init_seen_q | flag_init_end;
    debt_base   = done ? (debt_q - n_q) : debt_q;
    debt_d      = debt_base;
    ovf_d       = ovf_q;
    if (tick) begin
      if (debt_base == DEBT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_base + 1'b1;
      end
    end
  end

  // Outputs are decoded from next-state values so the registered copies line
  // up with the state they describe rather than trailing it by a cycle.
  always_comb begin
    req_d           = (state_d == IDLE) && (debt_d != '0);
    urgent_d        = (debt_d >= DEBT_URG);
    busy_d          = (state_d != IDLE);
    end_d           = (state_d == WAIT_RFC) && (left_d == '0) && (wait_d == RFC_LAST);
    cmd_d           = ref_cmd(state_d);
    addr_d          = '0;
    addr_d[A10_BIT] = (state_d == PRE);
  end

  // State, debt and output registers.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q     <= IDLE;
      debt_q      <= '0;
      n_q         <= '0;
      left_q      <= '0;
      wait_q      <= '0;
      init_seen_q <= 1'b0;
      req_q       <= 1'b0;
      urgent_q    <= 1'b0;
      busy_q      <= 1'b0;
      end_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      debt_q      <= debt_d;
      n_q         <= n_d;
      left_q      <= left_d;
      wait_q      <= wait_d;
      init_seen_q <= init_seen_d;
      req_q       <= req_d;
      urgent_q    <= urgent_d;
      busy_q      <= busy_d;
      end_q       <= end_d;
      ovf_q       <= ovf_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
    end
  end

  assign ref_req      = req_q;
  assign ref_urgent   = urgent_q;
  assign ref_busy     = busy_q;
  assign flag_ref_end = end_q;
  assign ref_overflow = ovf_q;
  assign sdram_cmd    = cmd_q;
  assign sdram_addr   = addr_q;
  assign sdram_bank   = '0;

endmodule

// File: tb/tb_sdram_ref_ctrl.sv
// Scoreboard bench for sdram_ref_ctrl: stimulus queues expected burst cycles,
// a negedge monitor pops and compares them whenever the engine is busy.
module tb_sdram_ref_ctrl;

  localparam int REF_PERIOD = 16;
  localparam int T_RP       = 2;
  localparam int T_RFC      = 4;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PREC = 4'b0010;
  localparam logic [3:0] AREFC = 4'b0001;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        fin;
  } exp_t;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic        flag_init_end;
  logic        ref_en;
  logic        ref_req;
  logic        ref_urgent;
  logic        ref_busy;
  logic        flag_ref_end;
  logic        ref_overflow;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   P;
  int   Q;
  logic mon_en = 1'b0;

  sdram_ref_ctrl #(
    .REF_PERIOD (REF_PERIOD),
    .T_RP       (T_RP),
    .T_RFC      (T_RFC),
    .MAX_DEBT   (8),
    .URGENT_TH  (6),
    .ADDR_W     (12),
    .BANK_W     (2),
    .A10_BIT    (10)
  ) dut (
    .sclk          (sclk),
    .s_rst         (s_rst),
    .flag_init_end (flag_init_end),
    .ref_en        (ref_en),
    .ref_req       (ref_req),
    .ref_urgent    (ref_urgent),
    .ref_busy      (ref_busy),
    .flag_ref_end  (flag_ref_end),
    .ref_overflow  (ref_overflow),
    .sdram_cmd     (sdram_cmd),
    .sdram_addr    (sdram_addr),
    .sdram_bank    (sdram_bank)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // Expected bus activity for a burst of n refreshes.
  task automatic push_burst(input int n);
    int   len;
    exp_t e;
    len = T_RP + n * T_RFC;
    for (int c = 0; c < len; c++) begin
      e      = '0;
      e.cmd  = NOP;
      e.fin  = (c == len - 1);
      if (c == 0) begin
        e.cmd     = PREC;
        e.addr[10] = 1'b1;
      end else if (c >= T_RP && ((c - T_RP) % T_RFC) == 0) begin
        e.cmd = AREFC;
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare every busy cycle against the scoreboard, idle cycles against NOP.
  always @(negedge sclk) begin
    exp_t e;
    if (mon_en) begin
      chk("bank_zero", sdram_bank, 0);
      if (ref_busy) begin
        if (exp_q.size() == 0) begin
          chk("busy_without_expect", ref_busy, 0);
        end else begin
          e = exp_q.pop_front();
          chk("burst_cmd", sdram_cmd, e.cmd);
          chk("burst_addr", sdram_addr, e.addr);
          chk("burst_end_flag", flag_ref_end, e.fin);
        end
      end else begin
        chk("idle_cmd", sdram_cmd, NOP);
        chk("idle_addr", sdram_addr, 0);
        chk("idle_end_flag", flag_ref_end, 0);
      end
    end
  end

  initial begin
    s_rst         = 1'b1;
    flag_init_end = 1'b0;
    ref_en        = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_cmd", sdram_cmd, NOP);
    chk("rst_req", ref_req, 0);
    chk("rst_urgent", ref_urgent, 0);
    chk("rst_busy", ref_busy, 0);
    chk("rst_end", flag_ref_end, 0);
    chk("rst_ovf", ref_overflow, 0);
    chk("rst_addr", sdram_addr, 0);
    s_rst  = 1'b0;
    mon_en = 1'b1;

    // Single refresh after the init pulse.
    goto(cyc + 3);
    P = cyc;
    flag_init_end = 1'b1;
    goto(P + 1);
    flag_init_end = 1'b0;
    goto(P + 16);
    chk("first_req_early", ref_req, 0);
    goto(P + 17);
    chk("first_req", ref_req, 1);
    push_burst(1);
    ref_en = 1'b1;
    goto(P + 18);
    ref_en = 1'b0;
    goto(P + 24);
    chk("n1_burst_len", exp_q.size(), 0);
    chk("n1_req_after", ref_req, 0);
    goto(P + 31);
    chk("n1_debt_zero", ref_req, 0);

    // Five postponed refreshes; a tick mid-burst lifts debt to 6 without extending it.
    goto(P + 33);
    chk("req_debt1", ref_req, 1);
    goto(P + 97);
    chk("debt5_not_urgent", ref_urgent, 0);
    push_burst(5);
    ref_en = 1'b1;
    goto(P + 98);
    ref_en = 1'b0;
    goto(P + 112);
    chk("mid_burst_not_urgent", ref_urgent, 0);
    goto(P + 113);
    chk("mid_burst_urgent", ref_urgent, 1);
    chk("mid_burst_req", ref_req, 0);
    goto(P + 120);
    chk("n5_burst_len", exp_q.size(), 0);
    chk("n5_leftover_req", ref_req, 1);
    chk("n5_leftover_urgent", ref_urgent, 0);

    // Accumulate to urgent, then saturate and overflow.
    goto(P + 192);
    chk("debt5_urgent_low", ref_urgent, 0);
    goto(P + 193);
    chk("debt6_urgent", ref_urgent, 1);
    goto(P + 240);
    chk("debt8_no_ovf", ref_overflow, 0);
    goto(P + 241);
    chk("ovf_set", ref_overflow, 1);
    push_burst(8);
    ref_en = 1'b1;
    goto(P + 242);
    ref_en = 1'b0;
    goto(P + 276);
    chk("n8_burst_len", exp_q.size(), 0);
    chk("n8_req_after", ref_req, 0);
    chk("n8_urgent_after", ref_urgent, 0);
    chk("ovf_sticky", ref_overflow, 1);

    // Tick coinciding with the last busy cycle of an n=2 burst.
    goto(P + 305);
    chk("req_debt2", ref_req, 1);
    goto(P + 310);
    push_burst(2);
    ref_en = 1'b1;
    goto(P + 311);
    ref_en = 1'b0;
    goto(P + 320);
    chk("n2_req_last_cycle", ref_req, 0);
    goto(P + 321);
    chk("n2_burst_len", exp_q.size(), 0);
    chk("n2_req_reassert", ref_req, 1);
    chk("n2_busy_low", ref_busy, 0);

    // Grant with zero debt and grant held through a burst are both ignored.
    push_burst(1);
    ref_en = 1'b1;
    goto(P + 322);
    ref_en = 1'b0;
    goto(P + 328);
    chk("drain_burst_len", exp_q.size(), 0);
    chk("drain_req", ref_req, 0);
    ref_en = 1'b1;
    for (int c = P + 329; c <= P + 336; c++) begin
      goto(c);
      chk("en_no_debt_busy", ref_busy, 0);
    end
    ref_en = 1'b0;
    goto(P + 337);
    chk("req_after_idle_en", ref_req, 1);
    push_burst(1);
    ref_en = 1'b1;
    goto(P + 344);
    ref_en = 1'b0;
    chk("held_en_burst_len", exp_q.size(), 0);
    chk("held_en_req", ref_req, 0);
    chk("held_en_busy", ref_busy, 0);

    // Reset in cycle 3 of a burst.
    goto(P + 353);
    chk("req_before_rst", ref_req, 1);
    push_burst(1);
    ref_en = 1'b1;
    goto(P + 354);
    ref_en = 1'b0;
    goto(P + 357);
    s_rst = 1'b1;
    goto(P + 358);
    s_rst = 1'b0;
    exp_q.delete();
    chk("midrst_cmd", sdram_cmd, NOP);
    chk("midrst_busy", ref_busy, 0);
    chk("midrst_req", ref_req, 0);
    chk("midrst_end", flag_ref_end, 0);
    chk("midrst_ovf", ref_overflow, 0);
    chk("midrst_urgent", ref_urgent, 0);
    for (int c = P + 359; c <= P + 400; c++) begin
      goto(c);
      chk("no_ref_before_init", ref_req, 0);
    end

    // Re-init restarts the refresh interval.
    Q = P + 402;
    goto(Q);
    flag_init_end = 1'b1;
    goto(Q + 1);
    flag_init_end = 1'b0;
    goto(Q + 16);
    chk("reinit_req_early", ref_req, 0);
    goto(Q + 17);
    chk("reinit_req", ref_req, 1);
    push_burst(1);
    ref_en = 1'b1;
    goto(Q + 18);
    ref_en = 1'b0;
    goto(Q + 24);
    chk("reinit_burst_len", exp_q.size(), 0);
    chk("reinit_req_after", ref_req, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
